stage5_control_unit: RTL and testbench

//  Multi-cycle control FSM: the driving end of the stage-5 datapath control interface.

---
 rtl/stage5_ctrl_pkg.sv | 58 +++++
 rtl/stage5_ctrl_decode.sv | 107 ++++++++++
 rtl/stage5_control_unit.sv | 119 +++++++++++
 tb/tb_stage5_control_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/stage5_ctrl_pkg.sv
// Shared definitions for the stage-5 control unit and the datapath that it drives.
// Covers opcode values, memory-port select encodings, FSM states and the control word.
package stage5_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PUSHI = 4'h1;
  localparam logic [3:0] OP_POP   = 4'h2;
  localparam logic [3:0] OP_ALU   = 4'h3;
  localparam logic [3:0] OP_JPOP  = 4'h4;
  localparam logic [3:0] OP_BR    = 4'h5;
  localparam logic [3:0] OP_BZ    = 4'h6;
  localparam logic [3:0] OP_CALL  = 4'h7;
  localparam logic [3:0] OP_RET   = 4'h8;
  localparam logic [3:0] OP_LOAD  = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] MD1_PC_IR     = 2'b00;
  localparam logic [1:0] MD1_MSP_VALB  = 2'b01;
  localparam logic [1:0] MD1_VALA_VALB = 2'b10;
  localparam logic [1:0] MD2_MSP_VALA  = 2'b00;
  localparam logic [1:0] MD2_RSP_VALA  = 2'b01;
  localparam logic [1:0] MDAT_RES      = 2'b00;
  localparam logic [1:0] MDAT_PC       = 2'b01;
  localparam logic [1:0] MDAT_VALB     = 2'b10;
  localparam logic [1:0] MDAT_ZEXT     = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH0, S_FETCH1, S_DECODE, S_EXEC, S_HALT
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       pcSource;
    logic       pcAdd;
    logic       mspWrite;
    logic       msPop;
    logic       rspWrite;
    logic       rsPop;
    logic       irWrite;
    logic       valAWrite;
    logic       valBWrite;
    logic       memRead1;
    logic       memRead2;
    logic       memWrite1;
    logic       memWrite2;
    logic [1:0] memDst1;
    logic [1:0] memDst2;
    logic [1:0] memData;
    logic       instrDone;
    logic       illegalOp;
    logic       halted;
  } ctrl_t;

  function automatic logic isIllegal(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/stage5_ctrl_decode.sv
// Pure combinational control-word generator: {state, step, opcode, ValAZero} -> enables.
// The last micro-step of each opcode raises instrDone, which the top uses to return to FETCH0.
module stage5_ctrl_decode
  import stage5_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] step,
  input  logic [3:0] opcode,
  input  logic [3:0] irOp,
  input  logic       valAZero,
  output ctrl_t      cw
);

  always_comb begin
    cw = '0;
    unique case (state)
      S_FETCH0: begin
        cw.memRead1 = 1'b1;
        cw.memDst1  = MD1_PC_IR;
        cw.pcWrite  = 1'b1;
      end
      S_FETCH1: cw.irWrite = 1'b1;
      // opcode register is not loaded yet, so DECODE looks at the IR directly
      S_DECODE: cw.illegalOp = isIllegal(irOp);
      S_HALT:   cw.halted = 1'b1;
      S_EXEC: begin
        case (opcode)
          OP_PUSHI: begin
            cw.memWrite2 = 1'b1; cw.memDst2 = MD2_MSP_VALA; cw.memData = MDAT_ZEXT;
            cw.mspWrite = 1'b1; cw.instrDone = 1'b1;
          end
          OP_POP: begin
            cw.mspWrite = 1'b1; cw.msPop = 1'b1; cw.instrDone = 1'b1;
          end
          OP_ALU: begin
            case (step)
              3'd0: begin
                cw.memRead1 = 1'b1; cw.memDst1 = MD1_MSP_VALB;
                cw.mspWrite = 1'b1; cw.msPop = 1'b1;
              end
              3'd1: begin
                cw.valBWrite = 1'b1; cw.memRead2 = 1'b1; cw.memDst2 = MD2_MSP_VALA;
                cw.mspWrite = 1'b1; cw.msPop = 1'b1;
              end
              3'd2: cw.valAWrite = 1'b1;
              3'd3: begin
                cw.memWrite2 = 1'b1; cw.memDst2 = MD2_MSP_VALA; cw.memData = MDAT_RES;
                cw.mspWrite = 1'b1; cw.instrDone = 1'b1;
              end
              default: ;
            endcase
          end
          OP_JPOP, OP_BZ, OP_RET: begin
            case (step)
              3'd0: begin
                cw.memRead2 = 1'b1;
                if (opcode == OP_RET) begin
                  cw.memDst2 = MD2_RSP_VALA; cw.rspWrite = 1'b1; cw.rsPop = 1'b1;
                end else begin
                  cw.memDst2 = MD2_MSP_VALA; cw.mspWrite = 1'b1; cw.msPop = 1'b1;
                end
              end
              3'd1: cw.valAWrite = 1'b1;
              3'd2: begin
                cw.instrDone = 1'b1;
                if (opcode != OP_BZ) begin
                  cw.pcWrite = 1'b1; cw.pcSource = 1'b1;
                end else if (valAZero) begin
                  cw.pcWrite = 1'b1; cw.pcAdd = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_BR: begin
            cw.pcWrite = 1'b1; cw.pcAdd = 1'b1; cw.instrDone = 1'b1;
          end
          OP_CALL: begin
            if (step == 3'd0) begin
              cw.memWrite2 = 1'b1; cw.memDst2 = MD2_RSP_VALA; cw.memData = MDAT_PC;
              cw.rspWrite = 1'b1;
            end else begin
              cw.pcWrite = 1'b1; cw.pcAdd = 1'b1; cw.instrDone = 1'b1;
            end
          end
          OP_LOAD: begin
            case (step)
              3'd0: begin cw.memRead2 = 1'b1; cw.memDst2 = MD2_MSP_VALA; end
              3'd1: cw.valAWrite = 1'b1;
              3'd2: begin cw.memRead1 = 1'b1; cw.memDst1 = MD1_VALA_VALB; end
              3'd3: cw.valBWrite = 1'b1;
              3'd4: begin
                cw.memWrite2 = 1'b1; cw.memDst2 = MD2_MSP_VALA; cw.memData = MDAT_VALB;
                cw.instrDone = 1'b1;
              end
              default: ;
            endcase
          end
          // NOP and the unassigned opcodes A-E finish in a single empty step
          default: cw.instrDone = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage5_control_unit.sv
// Multi-cycle stage-5 control FSM: fetch, decode, then per-opcode micro-steps.
// Holds the state/step/opcode registers; the control word comes from stage5_ctrl_decode.
module stage5_control_unit
  import stage5_ctrl_pkg::*;
#(
  parameter int OP_LSB = 12,
  parameter int OPW    = 4,
  parameter int ALUW   = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [15:0]     IROut,
  input  logic            ValAZero,
  output logic            PCWrite,
  output logic            PCSource,
  output logic            PCAdd,
  output logic            MSPWrite,
  output logic            MSPop,
  output logic            RSPWrite,
  output logic            RSPop,
  output logic            IRWrite,
  output logic            ValAWrite,
  output logic            ValBWrite,
  output logic            MemRead1,
  output logic            MemRead2,
  output logic            MemWrite1,
  output logic            MemWrite2,
  output logic [1:0]      MemDst1,
  output logic [1:0]      MemDst2,
  output logic [1:0]      MemData,
  output logic [ALUW-1:0] AluOp,
  output logic            InstrDone,
  output logic            IllegalOp,
  output logic            Halted
);

  state_t          state, stateNext;
  logic [2:0]      step, stepNext;
  logic [OPW-1:0]  opcode;
  logic [ALUW-1:0] aluOpQ;
  logic [OPW-1:0]  irOp;
  ctrl_t           cwRaw, cw;

  assign irOp = IROut[OP_LSB+OPW-1 -: OPW];

  stage5_ctrl_decode uDecode (
    .state   (state),
    .step    (step),
    .opcode  (opcode),
    .irOp    (irOp),
    .valAZero(ValAZero),
    .cw      (cwRaw)
  );

  always_comb begin
    stateNext = state;
    stepNext  = step;
    unique case (state)
      S_FETCH0: stateNext = S_FETCH1;
      S_FETCH1: stateNext = S_DECODE;
      S_DECODE: begin
        stepNext  = 3'd0;
        stateNext = (irOp == OP_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (cwRaw.instrDone) begin
          stateNext = S_FETCH0;
          stepNext  = 3'd0;
        end else begin
          stepNext = step + 3'd1;
        end
      end
      S_HALT:  stateNext = S_HALT;
      default: stateNext = S_FETCH0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= S_FETCH0;
      step   <= 3'd0;
      opcode <= '0;
      aluOpQ <= '0;
    end else begin
      state <= stateNext;
      step  <= stepNext;
      if (state == S_DECODE) begin
        opcode <= irOp;
        aluOpQ <= IROut[OP_LSB-1 -: ALUW];
      end
    end
  end

  // Reset silences the whole control word in the cycle it is asserted
  assign cw    = Reset ? '0 : cwRaw;
  assign AluOp = (!Reset && state == S_EXEC && opcode == OP_ALU) ? aluOpQ : '0;

  assign PCWrite   = cw.pcWrite;
  assign PCSource  = cw.pcSource;
  assign PCAdd     = cw.pcAdd;
  assign MSPWrite  = cw.mspWrite;
  assign MSPop     = cw.msPop;
  assign RSPWrite  = cw.rspWrite;
  assign RSPop     = cw.rsPop;
  assign IRWrite   = cw.irWrite;
  assign ValAWrite = cw.valAWrite;
  assign ValBWrite = cw.valBWrite;
  assign MemRead1  = cw.memRead1;
  assign MemRead2  = cw.memRead2;
  assign MemWrite1 = cw.memWrite1;
  assign MemWrite2 = cw.memWrite2;
  assign MemDst1   = cw.memDst1;
  assign MemDst2   = cw.memDst2;
  assign MemData   = cw.memData;
  assign InstrDone = cw.instrDone;
  assign IllegalOp = cw.illegalOp;
  assign Halted    = cw.halted;

endmodule

// File: tb/tb_stage5_control_unit.sv
// Scoreboard bench for stage5_control_unit: the stimulus queues the expected per-cycle outputs
// from an instruction-level model, and a negedge monitor compares them against the DUT.
module tb_stage5_control_unit;

  typedef struct packed {
    logic pcw, pcs, pca, mspw, mspop, rspw, rspop, irw, vaw, vbw, mr1, mr2, mw1, mw2;
    logic [1:0] d1, d2, md;
    logic [3:0] alu;
    logic done, ill, halt;
  } exp_t;

  logic CLK = 1'b0;
  logic Reset;
  logic [15:0] IROut;
  logic ValAZero;
  logic PCWrite, PCSource, PCAdd, MSPWrite, MSPop, RSPWrite, RSPop, IRWrite;
  logic ValAWrite, ValBWrite, MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0] MemDst1, MemDst2, MemData;
  logic [3:0] AluOp;
  logic InstrDone, IllegalOp, Halted;

  stage5_control_unit dut (
    .CLK(CLK), .Reset(Reset), .IROut(IROut), .ValAZero(ValAZero),
    .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
    .MSPWrite(MSPWrite), .MSPop(MSPop), .RSPWrite(RSPWrite), .RSPop(RSPop),
    .IRWrite(IRWrite), .ValAWrite(ValAWrite), .ValBWrite(ValBWrite),
    .MemRead1(MemRead1), .MemRead2(MemRead2), .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData), .AluOp(AluOp),
    .InstrDone(InstrDone), .IllegalOp(IllegalOp), .Halted(Halted)
  );

  always #5 CLK = ~CLK;

  exp_t  expQ[$];
  string tagQ[$];
  exp_t  seq[$];
  int    checks = 0;
  int    passed = 0;
  int    cyc = 0;

  always @(negedge CLK) begin
    exp_t act, ex;
    string tg;
    cyc++;
    if (expQ.size() > 0) begin
      ex = expQ.pop_front();
      tg = tagQ.pop_front();
      act = '{PCWrite, PCSource, PCAdd, MSPWrite, MSPop, RSPWrite, RSPop, IRWrite,
              ValAWrite, ValBWrite, MemRead1, MemRead2, MemWrite1, MemWrite2,
              MemDst1, MemDst2, MemData, AluOp, InstrDone, IllegalOp, Halted};
      checks++;
      if (act === ex) passed++;
      else $display("FAIL %s cyc=%0d got=%h want=%h", tg, cyc, act, ex);
    end
  end

  // Instruction-level model: fetch, decode, then the micro-operations of the opcode.
  task automatic genSeq(input logic [15:0] ir, input logic vaz);
    exp_t e;
    exp_t x[$];
    logic [3:0] op;
    op = ir[15:12];
    seq.delete();
    e = '0; e.mr1 = 1; e.pcw = 1; seq.push_back(e);
    e = '0; e.irw = 1; seq.push_back(e);
    e = '0; e.ill = (op >= 4'hA && op <= 4'hE); seq.push_back(e);
    if (op == 4'hF) return;
    case (op)
      4'h1: begin e = '0; e.mw2 = 1; e.md = 2'b11; e.mspw = 1; x.push_back(e); end
      4'h2: begin e = '0; e.mspw = 1; e.mspop = 1; x.push_back(e); end
      4'h3: begin
        e = '0; e.mr1 = 1; e.d1 = 2'b01; e.mspw = 1; e.mspop = 1; x.push_back(e);
        e = '0; e.vbw = 1; e.mr2 = 1; e.mspw = 1; e.mspop = 1; x.push_back(e);
        e = '0; e.vaw = 1; x.push_back(e);
        e = '0; e.mw2 = 1; e.md = 2'b00; e.mspw = 1; x.push_back(e);
      end
      4'h4, 4'h6, 4'h8: begin
        e = '0; e.mr2 = 1;
        if (op == 4'h8) begin e.d2 = 2'b01; e.rspw = 1; e.rspop = 1; end
        else begin e.mspw = 1; e.mspop = 1; end
        x.push_back(e);
        e = '0; e.vaw = 1; x.push_back(e);
        e = '0;
        if (op != 4'h6) begin e.pcw = 1; e.pcs = 1; end
        else if (vaz) begin e.pcw = 1; e.pca = 1; end
        x.push_back(e);
      end
      4'h5: begin e = '0; e.pcw = 1; e.pca = 1; x.push_back(e); end
      4'h7: begin
        e = '0; e.mw2 = 1; e.d2 = 2'b01; e.md = 2'b01; e.rspw = 1; x.push_back(e);
        e = '0; e.pcw = 1; e.pca = 1; x.push_back(e);
      end
      4'h9: begin
        e = '0; e.mr2 = 1; x.push_back(e);
        e = '0; e.vaw = 1; x.push_back(e);
        e = '0; e.mr1 = 1; e.d1 = 2'b10; x.push_back(e);
        e = '0; e.vbw = 1; x.push_back(e);
        e = '0; e.mw2 = 1; e.md = 2'b10; x.push_back(e);
      end
      default: begin e = '0; x.push_back(e); end
    endcase
    x[x.size()-1].done = 1'b1;
    foreach (x[i]) begin
      if (op == 4'h3) x[i].alu = ir[11:8];
      seq.push_back(x[i]);
    end
  endtask

  task automatic pushN(input int n, input string tg);
    for (int i = 0; i < n && i < seq.size(); i++) begin
      expQ.push_back(seq[i]);
      tagQ.push_back($sformatf("%s.c%0d", tg, i));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic runInstr(input logic [15:0] ir, input logic vaz, input string tg);
    IROut = ir; ValAZero = vaz;
    genSeq(ir, vaz);
    pushN(seq.size(), tg);
    tick(seq.size());
  endtask

  task automatic resetCycles(input int n, input string tg);
    Reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      expQ.push_back('0);
      tagQ.push_back(tg);
    end
    tick(n);
    Reset = 1'b0;
  endtask

  initial begin
    exp_t h;
    logic [15:0] ir;
    logic [3:0] ops [11];
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC};
    Reset = 1'b1; IROut = 16'h1234; ValAZero = 1'b0;
    @(posedge CLK); #1;
    resetCycles(3, "reset");
    runInstr(16'h1005, 1'b0, "pushi");
    runInstr(16'h3200, 1'b0, "alu");
    runInstr(16'h6000, 1'b1, "bzTaken");
    runInstr(16'h6000, 1'b0, "bzNot");
    runInstr(16'hB000, 1'b0, "illegal");
    runInstr(16'h7123, 1'b0, "call");
    runInstr(16'h8000, 1'b1, "ret");
    for (int k = 0; k < 40; k++) begin
      ir = 16'($urandom);
      ir[15:12] = ops[$urandom_range(0, 10)];
      runInstr(ir, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%0h", k, ir[15:12]));
    end
    // Reset lands on LOAD X2, abandoning the instruction
    IROut = 16'h9000; ValAZero = 1'b0;
    genSeq(16'h9000, 1'b0);
    pushN(5, "loadPre");
    tick(5);
    resetCycles(1, "rstLoadX2");
    runInstr(16'h0000, 1'b0, "nopAfterRst");
    // HALT holds until Reset
    IROut = 16'hF000;
    genSeq(16'hF000, 1'b0);
    pushN(3, "haltEntry");
    h = '0; h.halt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      expQ.push_back(h);
      tagQ.push_back($sformatf("halted%0d", i));
    end
    tick(23);
    resetCycles(1, "rstHalt");
    runInstr(16'h2000, 1'b0, "popAfterHalt");
    @(negedge CLK); #1;
    checks++;
    if (expQ.size() == 0) passed++;
    else $display("FAIL drain left=%0d want=0", expQ.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
